// File: rtl/led_frame_loader_if.sv
// ----------------------------------------------------------------------------
// led_frame_loader_if
//   Byte-command stream into the LED frame loader, valid/ready handshake.
//   A byte transfers on a rising edge where in_valid && in_ready.
//
//   Signals:
//     in_data   8  command/data byte          (master -> slave)
//     in_valid  1  in_data valid              (master -> slave)
//     in_ready  1  slave can take a byte      (slave  -> master)
//
//   Modports:
//     master  byte producer (upstream / testbench)
//     slave   byte consumer (led_frame_loader)
// ----------------------------------------------------------------------------
interface led_frame_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface : led_frame_loader_if

// File: rtl/led_frame_loader.sv
// ----------------------------------------------------------------------------
// led_frame_loader
//   Upstream stage of the 4x8 LED matrix driver. Decodes a byte-command
//   stream into a back buffer. The back buffer is copied to the front buffer
//   (leds1..leds4) only on frame_sync, so the driver never sees a torn frame.
//
//   Ports:
//     clk12MHz    in   1  system clock, rising edge
//     rst         in   1  synchronous active-high reset
//     s_in        slave led_frame_loader_if (in_data / in_valid / in_ready)
//     frame_sync  in   1  1-cycle pulse at the driver's scan wrap
//     leds1..4    out  8  front-buffer rows 1..4
//     leds_pwm    out  3  brightness to the driver
//     busy        out  1  commit pending, waiting for frame_sync
//     err         out  1  1-cycle pulse after an undefined command is accepted
//
//   Command bytes (interpreted in the command state):
//     0000_00rr  row header, the next accepted byte is written to back[rr]
//     1000_0bbb  brightness target = bbb
//     1100_0000  commit back -> front on the next frame_sync
//     1110_0000  clear the back buffer
//     others     ignored, err pulse
//
//   Configuration macro:
//     LED_FADE_EN  when defined, leds_pwm walks one step toward the target
//                  every FADE_DIV frame_sync pulses; otherwise leds_pwm
//                  follows the target one cycle after the brightness byte.
// ----------------------------------------------------------------------------
module led_frame_loader #(
    parameter logic [2:0] RESET_PWM = 3'd7,
    parameter int         FADE_DIV  = 4      // 1..255, used with LED_FADE_EN
) (
    input  logic                     clk12MHz,
    input  logic                     rst,
    led_frame_loader_if.slave        s_in,
    input  logic                     frame_sync,
    output logic [7:0]               leds1,
    output logic [7:0]               leds2,
    output logic [7:0]               leds3,
    output logic [7:0]               leds4,
    output logic [2:0]               leds_pwm,
    output logic                     busy,
    output logic                     err
);

    if (FADE_DIV < 1 || FADE_DIV > 255) begin : g_bad_fade_div
        $error("led_frame_loader: FADE_DIV must be in 1..255");
    end

    typedef enum logic {
        ST_CMD  = 1'b0,   // expecting a command byte
        ST_DATA = 1'b1    // expecting row data for r_row
    } state_t;

    localparam logic [7:0] CMD_COMMIT = 8'b1100_0000;
    localparam logic [7:0] CMD_CLEAR  = 8'b1110_0000;

    state_t     r_state;
    state_t     w_state_next;

    logic [1:0] r_row;
    logic [7:0] r_back  [4];
    logic [7:0] r_front [4];
    logic [2:0] r_target;
    logic       r_busy;
    logic       r_err;

    logic       w_accept;
    logic       w_latch_row;
    logic       w_write_row;
    logic       w_set_target;
    logic       w_commit;
    logic       w_clear;
    logic       w_bad_cmd;
    logic       w_copy;

    // Ready is combinational so upstream sees backpressure in the same cycle
    // busy rises; a commit freezes the back buffer until the copy is done.
    assign s_in.in_ready = !rst && !r_busy;
    assign w_accept      = s_in.in_valid && s_in.in_ready;

    // Copy only when a commit was already pending before this frame_sync; a
    // commit accepted in the same cycle waits for the next pulse.
    assign w_copy = r_busy && frame_sync;

    // ------------------------------------------------------------------------
    // FSM: next state and command decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_latch_row  = 1'b0;
        w_write_row  = 1'b0;
        w_set_target = 1'b0;
        w_commit     = 1'b0;
        w_clear      = 1'b0;
        w_bad_cmd    = 1'b0;

        if (w_accept) begin
            unique case (r_state)
                ST_CMD: begin
                    if (s_in.in_data[7:2] == 6'b0000_00) begin
                        w_latch_row  = 1'b1;
                        w_state_next = ST_DATA;
                    end else if (s_in.in_data[7:3] == 5'b1000_0) begin
                        w_set_target = 1'b1;
                    end else if (s_in.in_data == CMD_COMMIT) begin
                        w_commit = 1'b1;
                    end else if (s_in.in_data == CMD_CLEAR) begin
                        w_clear = 1'b1;
                    end else begin
                        w_bad_cmd = 1'b1;
                    end
                end
                ST_DATA: begin
                    // Any value is row data here, even command look-alikes.
                    w_write_row  = 1'b1;
                    w_state_next = ST_CMD;
                end
                default: w_state_next = ST_CMD;
            endcase
        end
    end

    always_ff @(posedge clk12MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: row index, back/front buffers, commit handshake, err pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            r_row    <= 2'd0;
            r_target <= RESET_PWM;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            // NOTE: the buffers are only 4 bytes each and the driver must show
            // a dark frame after reset, so they are reset like ordinary flops
            // rather than left as an unreset memory.
            for (int i = 0; i < 4; i++) begin
                r_back[i]  <= 8'h00;
                r_front[i] <= 8'h00;
            end
        end else begin
            r_err <= w_bad_cmd;

            if (w_latch_row) begin
                r_row <= s_in.in_data[1:0];
            end

            if (w_write_row) begin
                r_back[r_row] <= s_in.in_data;
            end

            if (w_clear) begin
                for (int i = 0; i < 4; i++) begin
                    r_back[i] <= 8'h00;
                end
            end

            if (w_set_target) begin
                r_target <= s_in.in_data[2:0];
            end

            // in_ready is low while busy, so w_commit and w_copy never coincide.
            if (w_copy) begin
                for (int i = 0; i < 4; i++) begin
                    r_front[i] <= r_back[i];
                end
                r_busy <= 1'b0;
            end else if (w_commit) begin
                r_busy <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Brightness
    // ------------------------------------------------------------------------
`ifdef LED_FADE_EN
    localparam logic [7:0] FADE_LAST = 8'(FADE_DIV - 1);

    logic [7:0] r_fade_cnt;
    logic [2:0] r_pwm;

    // The divider runs on every frame_sync independent of the target, so a new
    // target mid-fade redirects from the current value without a restart.
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            r_fade_cnt <= 8'd0;
            r_pwm      <= RESET_PWM;
        end else if (frame_sync) begin
            if (r_fade_cnt == FADE_LAST) begin
                r_fade_cnt <= 8'd0;
                if (r_pwm < r_target) begin
                    r_pwm <= r_pwm + 3'd1;
                end else if (r_pwm > r_target) begin
                    r_pwm <= r_pwm - 3'd1;
                end
            end else begin
                r_fade_cnt <= r_fade_cnt + 8'd1;
            end
        end
    end

    assign leds_pwm = r_pwm;
`else
    assign leds_pwm = r_target;
`endif

    assign leds1 = r_front[0];
    assign leds2 = r_front[1];
    assign leds3 = r_front[2];
    assign leds4 = r_front[3];
    assign busy  = r_busy;
    assign err   = r_err;

endmodule : led_frame_loader
